// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy / fill engine for the dual-port main-memory RAM.
// Port A streams reads, port B streams writes one cycle behind; overlapping copies run backward.
module mem_copy_engine #(
    parameter int DATA = 18,
    parameter int ADDR = 14
) (
    input  logic            clka,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic [ADDR-1:0] src,
    input  logic [ADDR-1:0] dst,
    input  logic [ADDR:0]   len,
    input  logic [DATA-1:0] fill_value,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [ADDR-1:0] ram_addra,
    input  logic [DATA-1:0] ram_douta,
    output logic [ADDR-1:0] ram_addrb,
    output logic            ram_web,
    output logic [DATA-1:0] ram_dinb
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    state_t          state, state_next;
    logic            fill_r, back_r, err_r;
    logic [ADDR:0]   cnt;
    logic [ADDR-1:0] dst_ptr, diff, off;
    logic [DATA-1:0] fill_word;
    logic            accept, bad, go, back, last, stop;

    assign diff = dst - src;
    assign off  = ADDR'(len - 1'b1);
    assign bad  = len[ADDR] && |len[ADDR-1:0];
    assign go   = !bad && len != '0;
    assign back = !mode && diff != '0 && {1'b0, diff} < len;
    assign last = cnt == {{ADDR{1'b0}}, 1'b1};
    assign stop = fill_r && last;

    assign busy     = state == READ || state == DRAIN;
    assign done     = state == FINISH;
    assign err      = done && err_r;
    assign ram_dinb = fill_r ? fill_word : ram_douta;

    always_comb begin
        accept     = start && (state == IDLE || state == FINISH);
        state_next = accept ? (go ? READ : FINISH)
                   : state == READ  ? (last ? (fill_r ? FINISH : DRAIN) : READ)
                   : state == DRAIN ? FINISH
                   : IDLE;
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Fill writes start on the accept edge; copy writes trail the reads by one cycle.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            fill_r    <= 1'b0;
            back_r    <= 1'b0;
            err_r     <= 1'b0;
            fill_word <= '0;
            cnt       <= '0;
            dst_ptr   <= '0;
            ram_addra <= '0;
            ram_addrb <= '0;
            ram_web   <= 1'b0;
        end else if (accept) begin
            fill_r    <= mode;
            back_r    <= back;
            err_r     <= bad;
            fill_word <= fill_value;
            cnt       <= len;
            ram_web   <= go && mode;
            ram_addrb <= (go && mode) ? dst : ram_addrb;
            ram_addra <= (go && !mode) ? (back ? src + off : src) : ram_addra;
            dst_ptr   <= mode ? dst + 1'b1 : (back ? dst + off : dst);
        end else if (state == READ) begin
            cnt     <= cnt - 1'b1;
            ram_web <= !stop;
            if (!stop) begin
                ram_addrb <= dst_ptr;
                dst_ptr   <= back_r ? dst_ptr - 1'b1 : dst_ptr + 1'b1;
            end
            if (!fill_r && !last) ram_addra <= back_r ? ram_addra - 1'b1 : ram_addra + 1'b1;
        end else begin
            ram_web <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed vectors against a behavioural RAM and a memmove/fill memory model.
module tb_mem_copy_engine;
    logic        clka = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic        mode = 0;
    logic [13:0] src = 0, dst = 0;
    logic [14:0] len = 0;
    logic [17:0] fill_value = 0;
    logic        busy, done, err, ram_web;
    logic [13:0] ram_addra, ram_addrb;
    logic [17:0] ram_douta, ram_dinb;

    logic [17:0] mem [0:16383];
    logic [17:0] img [0:16383];
    logic [17:0] exp_mem [0:16383];
    logic [17:0] old [0:16383];
    logic        load = 0;
    int          checks = 0, errors = 0;

    always #5 clka = ~clka;

    mem_copy_engine dut (
        .clka(clka), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill_value(fill_value), .busy(busy), .done(done), .err(err),
        .ram_addra(ram_addra), .ram_douta(ram_douta), .ram_addrb(ram_addrb),
        .ram_web(ram_web), .ram_dinb(ram_dinb)
    );

    always @(posedge clka) begin
        ram_douta <= mem[ram_addra];
        if (load) mem <= img;
        else if (ram_web) mem[ram_addrb] <= ram_dinb;
    end

    typedef struct {
        logic        m;
        logic [13:0] s, d;
        logic [14:0] l;
        logic [17:0] f;
        int          lat;
        logic        e;
        int          nw;
        logic [13:0] fa;
    } vec_t;
    vec_t v [10];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic model(input logic m, input logic [13:0] s, input logic [13:0] d,
                         input logic [14:0] l, input logic [17:0] f);
        old = exp_mem;
        if (l <= 15'h4000)
            for (int i = 0; i < int'(l); i++)
                exp_mem[d + 14'(i)] = m ? f : old[s + 14'(i)];
    endtask

    task automatic chk_mem(input string nm);
        int bad = 0;
        int first = 0;
        for (int i = 0; i < 16384; i++)
            if (mem[i] !== exp_mem[i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d words differ, first at %0h got %0h expected %0h",
                     nm, bad, first, mem[first], exp_mem[first]);
        end
    endtask

    // Issues one command and watches it until done (bounded), collecting timing and write stats.
    task automatic do_op(input logic m, input logic [13:0] s, input logic [13:0] d,
                         input logic [14:0] l, input logic [17:0] f,
                         output int lat, output logic e, output int nw, output logic [13:0] fa,
                         output int fw, output int nb, output logic bd);
        mode = m; src = s; dst = d; len = l; fill_value = f; start = 1;
        @(posedge clka); #1;
        start = 0;
        lat = -1; e = 0; nw = 0; fa = 0; fw = 0; nb = 0; bd = 0;
        for (int n = 1; n < 20000; n++) begin
            if (ram_web) begin
                if (nw == 0) begin fa = ram_addrb; fw = n; end
                nw++;
            end
            if (done) begin lat = n; e = err; bd = busy; break; end
            if (busy) nb++;
            @(posedge clka); #1;
        end
    endtask

    initial begin
        int lat, nw, fw, nb, d1, d2, nd;
        logic e, bd, b5, b6;
        logic [13:0] fa;

        v[0] = '{1'b0, 14'h0100, 14'h0200, 15'd4,      18'h0,     6,     1'b0, 4,     14'h0200};
        v[1] = '{1'b0, 14'h0010, 14'h0012, 15'd5,      18'h0,     7,     1'b0, 5,     14'h0016};
        v[2] = '{1'b1, 14'h0000, 14'h3FFE, 15'd4,      18'h2AAAA, 5,     1'b0, 4,     14'h3FFE};
        v[3] = '{1'b0, 14'h0100, 14'h0200, 15'd0,      18'h0,     1,     1'b0, 0,     14'h0000};
        v[4] = '{1'b0, 14'h0100, 14'h0200, 15'h4001,   18'h0,     1,     1'b1, 0,     14'h0000};
        v[5] = '{1'b0, 14'h0050, 14'h0050, 15'd3,      18'h0,     5,     1'b0, 3,     14'h0050};
        v[6] = '{1'b0, 14'h0030, 14'h002E, 15'd4,      18'h0,     6,     1'b0, 4,     14'h002E};
        v[7] = '{1'b0, 14'h3FFE, 14'h0000, 15'd4,      18'h0,     6,     1'b0, 4,     14'h0003};
        v[8] = '{1'b1, 14'h0000, 14'h0777, 15'd1,      18'h3FFFF, 2,     1'b0, 1,     14'h0777};
        v[9] = '{1'b1, 14'h0000, 14'h1234, 15'h4000,   18'h00155, 16385, 1'b0, 16384, 14'h1234};

        for (int i = 0; i < 16384; i++) img[i] = 18'(i * 7 + 3);
        for (int i = 0; i < 4; i++) img[16'h100 + i] = 18'(i + 1);
        for (int i = 0; i < 5; i++) img[16'h10 + i] = 18'(10 + i);
        exp_mem = img;
        load = 1;
        @(posedge clka); #1;
        load = 0;

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_web", ram_web, 0);
        chk("rst_addra", ram_addra, 0);
        chk("rst_addrb", ram_addrb, 0);
        @(posedge clka); #1;
        rst_n = 1;
        @(posedge clka); #1;

        for (int k = 0; k < 10; k++) begin
            model(v[k].m, v[k].s, v[k].d, v[k].l, v[k].f);
            do_op(v[k].m, v[k].s, v[k].d, v[k].l, v[k].f, lat, e, nw, fa, fw, nb, bd);
            chk($sformatf("v%0d_latency", k), lat, v[k].lat);
            chk($sformatf("v%0d_err", k), e, v[k].e);
            chk($sformatf("v%0d_writes", k), nw, v[k].nw);
            chk($sformatf("v%0d_first_addr", k), fa, v[k].fa);
            chk($sformatf("v%0d_first_write_cycle", k), fw, v[k].nw == 0 ? 0 : (v[k].m ? 1 : 2));
            chk($sformatf("v%0d_busy_cycles", k), nb, v[k].lat - 1);
            chk($sformatf("v%0d_busy_at_done", k), bd, 0);
            chk_mem($sformatf("v%0d_mem", k));
        end

        // Reset in cycle 3 of a forward len=8 copy: only word 0 (written at the end of cycle 2) lands.
        exp_mem[14'h300] = exp_mem[14'h100];
        mode = 0; src = 14'h100; dst = 14'h300; len = 15'd8; start = 1;
        @(posedge clka); #1;
        start = 0;
        @(posedge clka); #1;
        @(posedge clka); #1;
        chk("rst_mid_web_before", ram_web, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_web", ram_web, 0);
        chk("rst_mid_busy", busy, 0);
        nd = 0; nw = 0; nb = 0;
        for (int n = 0; n < 10; n++) begin
            if (n == 4) rst_n = 1;
            @(posedge clka); #1;
            nd += int'(done); nw += int'(ram_web); nb += int'(busy);
        end
        chk("rst_mid_no_done", nd, 0);
        chk("rst_mid_no_web", nw, 0);
        chk("rst_mid_no_busy", nb, 0);
        chk_mem("rst_mid_mem");
        model(1'b0, 14'h100, 14'h300, 15'd8, 18'h0);
        do_op(1'b0, 14'h100, 14'h300, 15'd8, 18'h0, lat, e, nw, fa, fw, nb, bd);
        chk("post_rst_latency", lat, 10);
        chk("post_rst_writes", nw, 8);
        chk("post_rst_first_addr", fa, 14'h300);
        chk_mem("post_rst_mem");

        // start held high: second command only taken on the FINISH edge of the first.
        model(1'b0, 14'h100, 14'h400, 15'd3, 18'h0);
        model(1'b0, 14'h200, 14'h500, 15'd2, 18'h0);
        mode = 0; src = 14'h100; dst = 14'h400; len = 15'd3; start = 1;
        @(posedge clka); #1;
        src = 14'h200; dst = 14'h500; len = 15'd2;
        d1 = 0; d2 = 0; nd = 0; nw = 0; b5 = 1; b6 = 0;
        for (int n = 1; n <= 20; n++) begin
            if (ram_web) nw++;
            if (n == 5) b5 = busy;
            if (n == 6) b6 = busy;
            if (done) begin
                nd++;
                if (d1 == 0) d1 = n;
                else if (d2 == 0) begin d2 = n; start = 0; end
            end
            @(posedge clka); #1;
        end
        start = 0;
        chk("hold_done1", d1, 5);
        chk("hold_done2", d2, 9);
        chk("hold_done_count", nd, 2);
        chk("hold_writes", nw, 5);
        chk("hold_busy_finish", b5, 0);
        chk("hold_busy_second", b6, 1);
        chk_mem("hold_mem");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
